// File: rtl/muldiv_alu_ctrl.sv
// ALU control decoder with an iterative multiply/divide unit and the HI/LO registers.
// Multiply uses shift-add and divide uses restoring division. Each takes one iteration per cycle.
module muldiv_alu_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [3:0]       ALUOp,
  input  logic [5:0]       FuncCode,
  input  logic             Valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [3:0]       ALUCtrl,
  output logic             IllegalFunc,
  output logic             Stall,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] MDResult
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  localparam logic [5:0] FnMfhi = 6'b010000;
  localparam logic [5:0] FnMthi = 6'b010001;
  localparam logic [5:0] FnMflo = 6'b010010;
  localparam logic [5:0] FnMtlo = 6'b010011;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;     // {partial product} or {remainder, quotient}
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic               mul_q, mul_d;
  logic               neg_lo_q, neg_lo_d; // negate product / quotient
  logic               neg_hi_q, neg_hi_d; // negate remainder
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic               rtype, is_md, accept, signed_op, mul_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_trial, div_diff;

  assign rtype = (ALUOp == 4'b1111);

  // Decode ALU control and classify the funct field
  always_comb begin
    ALUCtrl     = ALUOp;
    IllegalFunc = 1'b0;
    is_md       = 1'b0;
    if (rtype) begin
      ALUCtrl = 4'b1111;
      case (FuncCode)
        6'b000000: ALUCtrl = 4'b0011;
        6'b000010: ALUCtrl = 4'b0100;
        6'b000011: ALUCtrl = 4'b1101;
        6'b100000: ALUCtrl = 4'b0010;
        6'b100001: ALUCtrl = 4'b1000;
        6'b100010: ALUCtrl = 4'b0110;
        6'b100011: ALUCtrl = 4'b1001;
        6'b100100: ALUCtrl = 4'b0000;
        6'b100101: ALUCtrl = 4'b0001;
        6'b100110: ALUCtrl = 4'b1010;
        6'b100111: ALUCtrl = 4'b1100;
        6'b101010: ALUCtrl = 4'b0111;
        6'b101011: ALUCtrl = 4'b1011;
        6'b010000, 6'b010001, 6'b010010, 6'b010011,
        6'b011000, 6'b011001, 6'b011010, 6'b011011: is_md = 1'b1;
        default: IllegalFunc = 1'b1;
      endcase
    end
  end

  // Operand conditioning; funct bit 0 selects unsigned, bit 1 selects divide
  always_comb begin
    signed_op = ~FuncCode[0];
    mul_op    = ~FuncCode[1];
    a_neg     = signed_op & A[WIDTH-1];
    b_neg     = signed_op & B[WIDTH-1];
    a_mag     = a_neg ? -A : A;
    b_mag     = b_neg ? -B : B;
    accept    = Valid & is_md & (state_q == StIdle) & (FuncCode[5:2] == 4'b0110);
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opnd_q};
  end

  // Next-state logic for the iterative unit and the HI/LO registers
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    mul_d    = mul_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d = '0;
          mul_d = mul_op;
          if (mul_op) begin
            acc_d    = {{WIDTH{1'b0}}, b_mag};
            opnd_d   = a_mag;
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg ^ b_neg;
            state_d  = StMul;
          end else if (B == '0) begin
            // Divide by zero: result is preloaded and FIX passes it through
            acc_d    = {A, {WIDTH{1'b1}}};
            neg_lo_d = 1'b0;
            neg_hi_d = 1'b0;
            state_d  = StFix;
          end else begin
            acc_d    = {{WIDTH{1'b0}}, a_mag};
            opnd_d   = b_mag;
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg;
            state_d  = StDiv;
          end
        end else if (Valid && is_md && FuncCode == FnMthi) begin
          hi_d = A;
        end else if (Valid && is_md && FuncCode == FnMtlo) begin
          lo_d = A;
        end
      end
      StMul: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) state_d = StFix;
      end
      StDiv: begin
        // A borrow out of the trial subtraction means the remainder is restored
        if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else                  acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) state_d = StFix;
      end
      StFix: begin
        if (mul_q) begin
          {hi_d, lo_d} = neg_lo_q ? -acc_q : acc_q;
        end else begin
          hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      mul_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      mul_q    <= mul_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign Busy     = (state_q != StIdle);
  assign Done     = done_q;
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign Stall    = Valid & Busy & is_md;
  assign MDResult = (is_md && FuncCode == FnMfhi) ? hi_q :
                    (is_md && FuncCode == FnMflo) ? lo_q : '0;

endmodule

// File: tb/tb_muldiv_alu_ctrl.sv
// Bench for muldiv_alu_ctrl at WIDTH=32. It checks the decode table, the multiply/divide
// results through a scoreboard, and the stall, reset and HI/LO move sequences.
module tb_muldiv_alu_ctrl;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst, valid;
  logic [3:0]    aluop;
  logic [5:0]    func;
  logic [W-1:0]  a, b;
  logic [3:0]    alu_ctrl;
  logic          illegal, stall, busy, done;
  logic [W-1:0]  hi, lo, mdres;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb_q[$];

  typedef struct {logic [3:0] op; logic [5:0] fn; logic [3:0] ctrl; logic ill;} dec_t;
  typedef struct {logic [5:0] fn; logic [31:0] x; logic [31:0] y;} md_t;

  always #5 clk = ~clk;

  muldiv_alu_ctrl #(.WIDTH(W)) dut (
    .Clk(clk), .Rst(rst), .ALUOp(aluop), .FuncCode(func), .Valid(valid), .A(a), .B(b),
    .ALUCtrl(alu_ctrl), .IllegalFunc(illegal), .Stall(stall), .Busy(busy), .Done(done),
    .HI(hi), .LO(lo), .MDResult(mdres)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    valid = 1'b0; aluop = 4'b0000; func = 6'b000000; a = '0; b = '0;
  endtask

  function automatic logic [63:0] md_model(input logic [5:0] f, input logic [31:0] x,
                                           input logic [31:0] y);
    longint sx, sy;
    int ix, iy, q, r;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    ix = x;
    iy = y;
    p = '0;
    case (f)
      6'b011000: p = 64'(sx * sy);
      6'b011001: p = {32'b0, x} * {32'b0, y};
      6'b011010: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) p = {32'h0, 32'h8000_0000};
        else begin
          q = ix / iy;
          r = ix % iy;
          p = {32'(r), 32'(q)};
        end
      end
      default: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else p = {x % y, x / y};
      end
    endcase
    return p;
  endfunction

  task automatic issue(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    valid = 1'b1; aluop = 4'b1111; func = f; a = x; b = y;
    sb_q.push_back(md_model(f, x, y));
    tick();
    idle_in();
  endtask

  // Wait (bounded) for Done; leaves the bench in the Done cycle
  task automatic wait_done(input string name, input int exp_lat);
    int n = 0;
    int busy_n = 0;
    logic [63:0] e;
    while (!done && n < 200) begin
      if (busy) busy_n++;
      tick();
      n++;
    end
    check({name, " latency"}, 64'(n), 64'(exp_lat));
    check({name, " busy cycles"}, 64'(busy_n), 64'(exp_lat));
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got result with no expected entry queued", name);
    end else begin
      e = sb_q.pop_front();
      check({name, " hi:lo"}, {hi, lo}, e);
    end
  endtask

  task automatic run_md(input string name, input logic [5:0] f, input logic [31:0] x,
                        input logic [31:0] y);
    issue(f, x, y);
    wait_done(name, (f[1] && y == 0) ? 1 : W + 1);
    tick();
    check({name, " done pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    dec_t dec_tab[$];
    md_t  md_tab[$];
    int   stall_lost;
    logic [31:0] rx, ry;

    idle_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset hi", 64'(hi), 64'(0));
    check("reset lo", 64'(lo), 64'(0));

    dec_tab.push_back('{4'b0010, 6'b000000, 4'b0010, 1'b0});
    dec_tab.push_back('{4'b0110, 6'b111111, 4'b0110, 1'b0});
    dec_tab.push_back('{4'b1111, 6'b000000, 4'b0011, 1'b0});
    dec_tab.push_back('{4'b1111, 6'b000010, 4'b0100, 1'b0});
    dec_tab.push_back('{4'b1111, 6'b000011, 4'b1101, 1'b0});
    dec_tab.push_back('{4'b1111, 6'b100000, 4'b0010, 1'b0});
    dec_tab.push_back('{4'b1111, 6'b100001, 4'b1000, 1'b0});
    dec_tab.push_back('{4'b1111, 6'b100010, 4'b0110, 1'b0});
    dec_tab.push_back('{4'b1111, 6'b100011, 4'b1001, 1'b0});
    dec_tab.push_back('{4'b1111, 6'b100100, 4'b0000, 1'b0});
    dec_tab.push_back('{4'b1111, 6'b100101, 4'b0001, 1'b0});
    dec_tab.push_back('{4'b1111, 6'b100110, 4'b1010, 1'b0});
    dec_tab.push_back('{4'b1111, 6'b100111, 4'b1100, 1'b0});
    dec_tab.push_back('{4'b1111, 6'b101010, 4'b0111, 1'b0});
    dec_tab.push_back('{4'b1111, 6'b101011, 4'b1011, 1'b0});
    dec_tab.push_back('{4'b1111, 6'b010000, 4'b1111, 1'b0});
    dec_tab.push_back('{4'b1111, 6'b010011, 4'b1111, 1'b0});
    dec_tab.push_back('{4'b1111, 6'b011000, 4'b1111, 1'b0});
    dec_tab.push_back('{4'b1111, 6'b011011, 4'b1111, 1'b0});
    dec_tab.push_back('{4'b1111, 6'b111111, 4'b1111, 1'b1});
    dec_tab.push_back('{4'b1111, 6'b000001, 4'b1111, 1'b1});
    dec_tab.push_back('{4'b1111, 6'b010100, 4'b1111, 1'b1});
    foreach (dec_tab[i]) begin
      aluop = dec_tab[i].op;
      func  = dec_tab[i].fn;
      #1;
      check($sformatf("decode ctrl %b/%b", aluop, func), 64'(alu_ctrl), 64'(dec_tab[i].ctrl));
      check($sformatf("decode illegal %b/%b", aluop, func), 64'(illegal), 64'(dec_tab[i].ill));
      tick();
    end
    idle_in();

    md_tab.push_back('{6'b011000, 32'hFFFF_FFFD, 32'h0000_0007});
    md_tab.push_back('{6'b011000, 32'h8000_0000, 32'h8000_0000});
    md_tab.push_back('{6'b011000, 32'h0000_1234, 32'hFFFF_FFFB});
    md_tab.push_back('{6'b011001, 32'h1234_5678, 32'h9ABC_DEF0});
    md_tab.push_back('{6'b011011, 32'd100, 32'd7});
    md_tab.push_back('{6'b011010, 32'hFFFF_FFF9, 32'h0000_0002});
    md_tab.push_back('{6'b011010, 32'h8000_0000, 32'hFFFF_FFFF});
    md_tab.push_back('{6'b011010, 32'h0000_0007, 32'hFFFF_FFFE});
    md_tab.push_back('{6'b011011, 32'hFFFF_FFFF, 32'h0000_0000});
    md_tab.push_back('{6'b011011, 32'hFFFF_FFFF, 32'h0000_0001});
    foreach (md_tab[i])
      run_md($sformatf("md %b %h/%h", md_tab[i].fn, md_tab[i].x, md_tab[i].y),
             md_tab[i].fn, md_tab[i].x, md_tab[i].y);

    for (int i = 0; i < 6; i++) begin
      rx = $urandom;
      ry = (i == 3) ? 32'h0 : $urandom;
      run_md($sformatf("rand %0d", i), {4'b0110, 2'($urandom_range(0, 3))}, rx, ry);
    end

    // MULTU with MFLO waiting in decode
    issue(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    valid = 1'b1; aluop = 4'b1111; func = 6'b010010;
    stall_lost = 0;
    for (int n = 0; n < 200 && busy; n++) begin
      #1;
      if (!stall) stall_lost++;
      tick();
    end
    #1;
    check("mflo stall held while busy", 64'(stall_lost), 64'(0));
    check("mflo stall dropped", 64'(stall), 64'(0));
    check("mflo mdresult", 64'(mdres), 64'h1);
    check("mflo hi", 64'(hi), 64'hFFFF_FFFE);
    check("mflo done", 64'(done), 64'(1));
    if (sb_q.size() != 0) check("mflo hi:lo", {hi, lo}, sb_q.pop_front());
    idle_in();
    tick();

    // Non-MD never stalls; MD while busy is stalled and ignored
    issue(6'b011011, 32'd1000, 32'd3);
    valid = 1'b1; aluop = 4'b1111; func = 6'b100000;
    #1;
    check("add while busy stall", 64'(stall), 64'(0));
    check("add while busy ctrl", 64'(alu_ctrl), 64'(4'b0010));
    tick();
    func = 6'b010001; a = 32'hDEAD_BEEF;
    #1;
    check("mthi while busy stall", 64'(stall), 64'(1));
    tick();
    func = 6'b011000; a = 32'd3; b = 32'd3;
    tick();
    idle_in();
    wait_done("divu with stalled mthi", W + 1 - 3);
    tick();
    check("stalled mult not accepted", 64'(busy), 64'(0));
    check("stalled seq done pulse", 64'(done), 64'(0));

    // Divide by zero, then MTLO in the Done cycle
    issue(6'b011010, 32'd5, 32'd0);
    wait_done("div by zero", 1);
    valid = 1'b1; aluop = 4'b1111; func = 6'b010011; a = 32'h1234;
    tick();
    idle_in();
    check("mtlo lo", 64'(lo), 64'h1234);
    check("mtlo hi kept", 64'(hi), 64'h5);
    check("mtlo done", 64'(done), 64'(0));
    check("mtlo busy", 64'(busy), 64'(0));

    // MTHI / MFHI while idle
    valid = 1'b1; aluop = 4'b1111; func = 6'b010001; a = 32'hCAFE_F00D;
    tick();
    check("mthi hi", 64'(hi), 64'hCAFE_F00D);
    check("mthi busy", 64'(busy), 64'(0));
    check("mthi done", 64'(done), 64'(0));
    valid = 1'b0; func = 6'b010000;
    #1;
    check("mfhi mdresult", 64'(mdres), 64'hCAFE_F00D);
    func = 6'b100000;
    #1;
    check("add mdresult", 64'(mdres), 64'h0);
    idle_in();
    tick();

    // Reset on cycle 10 of a DIV
    issue(6'b011010, 32'd1000, 32'd3);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    check("mid reset busy", 64'(busy), 64'(0));
    check("mid reset hi", 64'(hi), 64'(0));
    check("mid reset lo", 64'(lo), 64'(0));
    check("mid reset done", 64'(done), 64'(0));
    tick();
    check("mid reset stays idle", 64'(busy), 64'(0));

    // Reset beats a same-cycle MTHI and a same-cycle accept
    rst = 1'b1; valid = 1'b1; aluop = 4'b1111; func = 6'b010001; a = 32'h77;
    tick();
    func = 6'b011000; a = 32'd9; b = 32'd9;
    tick();
    rst = 1'b0;
    idle_in();
    check("reset over mthi hi", 64'(hi), 64'(0));
    check("reset over accept busy", 64'(busy), 64'(0));

    run_md("mult after reset", 6'b011000, 32'd1234, 32'hFFFF_FFFB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
